// File: rtl/hidden_layer_sched.sv
// One shared MAC computes N_NEUR ReLU neurons of N_IN signed bytes each; weights/bias come from
// synchronous memories (data one cycle after address), N_IN+3 cycles per neuron; start is only taken in IDLE.
module hidden_layer_sched #(
   parameter int N_IN   = 32,
   parameter int N_NEUR = 8,
   localparam int AW    = $clog2(N_IN * N_NEUR),
   localparam int NW    = (N_NEUR > 1) ? $clog2(N_NEUR) : 1,
   localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [8*N_IN-1:0]   in_vec,
   output logic [AW-1:0]       w_addr,
   input  logic [7:0]          w_data,
   output logic [NW-1:0]       b_addr,
   input  logic [7:0]          b_data,
   output logic [8*N_NEUR-1:0] out_vec,
   output logic                busy,
   output logic                done
);

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_DRAIN, S_BIAS, S_ACT, S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NW-1:0]        r_n;
   logic [IW-1:0]        r_i;
   logic [IW-1:0]        r_k;
   logic                 r_mac_vld;
   logic signed [23:0]   r_acc;
   logic [7:0]           r_in [N_IN];
   logic [8*N_NEUR-1:0]  r_out;
   logic signed [15:0]   w_prod;
   logic [7:0]           w_relu;
   logic                 w_last_i;
   logic                 w_last_n;

   assign w_last_i = (r_i == IW'(N_IN - 1));
   assign w_last_n = (r_n == NW'(N_NEUR - 1));
   assign w_prod   = $signed(r_in[r_k]) * $signed(w_data);
   assign out_vec  = r_out;

   always_comb begin
      w_relu = r_acc[7:0];
      if (r_acc[23])
         w_relu = 8'd0;
      else if (r_acc > 24'sd127)
         w_relu = 8'd127;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_MAC;
         S_MAC:   if (w_last_i) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = S_BIAS;
         S_BIAS:  w_state_nxt = S_ACT;
         S_ACT:   w_state_nxt = w_last_n ? S_DONE : S_MAC;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      done   = 1'b0;
      w_addr = '0;
      b_addr = '0;
      case (r_state)
         S_MAC: begin
            busy   = 1'b1;
            w_addr = AW'(r_n) * AW'(N_IN) + AW'(r_i);
            b_addr = r_n;
         end
         S_DRAIN, S_BIAS, S_ACT: begin
            busy   = 1'b1;
            b_addr = r_n;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // r_k/r_mac_vld trail the issued address by one cycle to line up with w_data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n       <= '0;
         r_i       <= '0;
         r_k       <= '0;
         r_mac_vld <= 1'b0;
         r_acc     <= '0;
         r_out     <= '0;
      end else begin
         r_mac_vld <= (r_state == S_MAC);
         r_k       <= r_i;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int j = 0; j < N_IN; j++)
                     r_in[j] <= in_vec[8*j +: 8];
                  r_n   <= '0;
                  r_i   <= '0;
                  r_acc <= '0;
               end
            end
            S_MAC: begin
               r_i <= w_last_i ? '0 : r_i + IW'(1);
               if (r_mac_vld)
                  r_acc <= r_acc + {{8{w_prod[15]}}, w_prod};
            end
            S_DRAIN: begin
               if (r_mac_vld)
                  r_acc <= r_acc + {{8{w_prod[15]}}, w_prod};
            end
            S_BIAS: r_acc <= r_acc + {{16{b_data[7]}}, b_data};
            S_ACT: begin
               r_out[8*r_n +: 8] <= w_relu;
               r_acc             <= '0;
               r_i               <= '0;
               if (!w_last_n)
                  r_n <= r_n + NW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
